// File: rtl/decode_buffer.sv
// decode_buffer: FIFO of fetched {pc, instr} pairs with combinational RV32I decode of the head entry
//   clk, rst_n       : clock, asynchronous active-low reset
//   flush            : synchronous discard of all buffered entries (beats push/pop)
//   in_valid/in_ready, in_pc, in_instr : fetch-side handshake and payload
//   out_valid/out_ready                : downstream handshake
//   out_pc, out_opcode..out_funct7, out_imm : decoded fields of the head entry
//   out_reg_write..out_illegal         : control flags, forced to 0 when out_valid=0
//   out_count        : current occupancy
module decode_buffer #(
    parameter int ADDR_WIDTH  = 12,
    parameter int INSTR_WIDTH = 32,
    parameter int DEPTH       = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_WIDTH-1:0]      in_pc,
    input  logic [INSTR_WIDTH-1:0]     in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ADDR_WIDTH-1:0]      out_pc,
    output logic [6:0]                 out_opcode,
    output logic [4:0]                 out_rd,
    output logic [2:0]                 out_funct3,
    output logic [4:0]                 out_rs1,
    output logic [4:0]                 out_rs2,
    output logic [6:0]                 out_funct7,
    output logic [31:0]                out_imm,
    output logic                       out_reg_write,
    output logic                       out_mem_read,
    output logic                       out_mem_write,
    output logic                       out_branch,
    output logic                       out_jump,
    output logic                       out_alu_src,
    output logic                       out_illegal,
    output logic [$clog2(DEPTH):0]     out_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_WIDTH-1:0]  r_pc    [DEPTH];
    logic [INSTR_WIDTH-1:0] r_instr [DEPTH];
    logic [PW-1:0]          r_wr_ptr;
    logic [PW-1:0]          r_rd_ptr;
    logic [CW-1:0]          r_count;
    logic                   w_push;
    logic                   w_pop;
    logic [31:0]            w_instr;
    logic [6:0]             w_op;
    logic [31:0]            w_imm;
    logic [6:0]             w_flags;

    assign in_ready  = r_count != CW'(DEPTH);
    assign out_valid = r_count != '0;
    assign w_push    = in_valid & in_ready & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;
    assign out_count = r_count;

    // Power-of-two DEPTH lets the pointers wrap by natural overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]    <= in_pc;
            r_instr[r_wr_ptr] <= in_instr;
        end
    end

    assign w_instr    = r_instr[r_rd_ptr];
    assign w_op       = w_instr[6:0];
    assign out_pc     = r_pc[r_rd_ptr];
    assign out_opcode = w_op;
    assign out_rd     = w_instr[11:7];
    assign out_funct3 = w_instr[14:12];
    assign out_rs1    = w_instr[19:15];
    assign out_rs2    = w_instr[24:20];
    assign out_funct7 = w_instr[31:25];
    assign out_imm    = w_imm;

    // w_flags = {reg_write, mem_read, mem_write, branch, jump, alu_src, illegal}
    always_comb begin
        w_imm   = '0;
        w_flags = 7'b0000001;
        case (w_op)
            7'b0110011: w_flags = 7'b1000000;
            7'b0010011: begin
                w_imm   = {{20{w_instr[31]}}, w_instr[31:20]};
                w_flags = 7'b1000010;
            end
            7'b0000011: begin
                w_imm   = {{20{w_instr[31]}}, w_instr[31:20]};
                w_flags = 7'b1100010;
            end
            7'b1100111: begin
                w_imm   = {{20{w_instr[31]}}, w_instr[31:20]};
                w_flags = 7'b1000110;
            end
            7'b0100011: begin
                w_imm   = {{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
                w_flags = 7'b0010010;
            end
            7'b1100011: begin
                w_imm   = {{20{w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
                w_flags = 7'b0001000;
            end
            7'b0110111, 7'b0010111: begin
                w_imm   = {w_instr[31:12], 12'b0};
                w_flags = 7'b1000010;
            end
            7'b1101111: begin
                w_imm   = {{12{w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};
                w_flags = 7'b1000100;
            end
            default: ;
        endcase
    end

    assign out_reg_write = w_flags[6] & out_valid;
    assign out_mem_read  = w_flags[5] & out_valid;
    assign out_mem_write = w_flags[4] & out_valid;
    assign out_branch    = w_flags[3] & out_valid;
    assign out_jump      = w_flags[2] & out_valid;
    assign out_alu_src   = w_flags[1] & out_valid;
    assign out_illegal   = w_flags[0] & out_valid;
endmodule

// File: tb/tb_decode_buffer.sv
// tb_decode_buffer: scoreboard bench for decode_buffer with directed and random traffic
module tb_decode_buffer;
    localparam int AW = 12;
    localparam int DEPTH = 2;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        flush = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [AW-1:0] in_pc = '0;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 0;
    logic [AW-1:0] out_pc;
    logic [6:0]  out_opcode;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [6:0]  out_funct7;
    logic [31:0] out_imm;
    logic        out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src, out_illegal;
    logic [1:0]  out_count;

    decode_buffer #(.ADDR_WIDTH(AW), .INSTR_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7), .out_imm(out_imm),
        .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
        .out_branch(out_branch), .out_jump(out_jump), .out_alu_src(out_alu_src),
        .out_illegal(out_illegal), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] pc;
        logic [31:0]   instr;
        logic [31:0]   imm;
        logic [6:0]    flags;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    wire [6:0] w_fl = {out_reg_write, out_mem_read, out_mem_write, out_branch, out_jump, out_alu_src, out_illegal};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t ref_dec(input logic [AW-1:0] pc, input logic [31:0] x);
        exp_t e;
        logic [12:0] b;
        logic [20:0] j;
        logic [11:0] s;
        e.pc = pc;
        e.instr = x;
        b = {x[31], x[7], x[30:25], x[11:8], 1'b0};
        j = {x[31], x[19:12], x[20], x[30:21], 1'b0};
        s = {x[31:25], x[11:7]};
        e.imm = 0;
        case (x[6:0])
            7'h33: e.flags = 7'b1000000;
            7'h13: begin e.flags = 7'b1000010; e.imm = 32'($signed(x[31:20])); end
            7'h03: begin e.flags = 7'b1100010; e.imm = 32'($signed(x[31:20])); end
            7'h67: begin e.flags = 7'b1000110; e.imm = 32'($signed(x[31:20])); end
            7'h23: begin e.flags = 7'b0010010; e.imm = 32'($signed(s)); end
            7'h63: begin e.flags = 7'b0001000; e.imm = 32'($signed(b)); end
            7'h37, 7'h17: begin e.flags = 7'b1000010; e.imm = x[31:12] * 4096; end
            7'h6F: begin e.flags = 7'b1000100; e.imm = 32'($signed(j)); end
            default: e.flags = 7'b0000001;
        endcase
        return e;
    endfunction

    // Reference occupancy model: inputs are stable across posedge, decisions use pre-edge state
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) q.delete();
        else begin
            automatic bit can_push = q.size() < DEPTH;
            automatic bit do_pop = q.size() != 0 && out_ready;
            if (do_pop) void'(q.pop_front());
            if (can_push && in_valid) q.push_back(ref_dec(in_pc, in_instr));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("count", 32'(out_count), 32'(q.size()));
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
            if (q.size() != 0) begin
                chk("pc", 32'(out_pc), 32'(q[0].pc));
                chk("opcode", 32'(out_opcode), 32'(q[0].instr[6:0]));
                chk("rd", 32'(out_rd), 32'(q[0].instr[11:7]));
                chk("funct3", 32'(out_funct3), 32'(q[0].instr[14:12]));
                chk("rs1", 32'(out_rs1), 32'(q[0].instr[19:15]));
                chk("rs2", 32'(out_rs2), 32'(q[0].instr[24:20]));
                chk("funct7", 32'(out_funct7), 32'(q[0].instr[31:25]));
                chk("imm", out_imm, q[0].imm);
                chk("flags", 32'(w_fl), 32'(q[0].flags));
            end else chk("flags_masked", 32'(w_fl), 32'd0);
        end
    end

    task automatic cyc(input logic iv, input logic [AW-1:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
        in_valid = iv;
        in_pc = pc;
        in_instr = ins;
        out_ready = ordy;
        flush = fl;
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops[10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        cyc(1, 12'h000, 32'h00500093, 0, 0);
        chk("addi_valid", 32'(out_valid), 32'd1);
        chk("addi_rd", 32'(out_rd), 32'd1);
        chk("addi_rs1", 32'(out_rs1), 32'd0);
        chk("addi_imm", out_imm, 32'h5);
        chk("addi_flags", 32'(w_fl), 32'b1000010);
        cyc(0, 0, 0, 1, 0);
        chk("addi_pop", 32'(out_count), 32'd0);
        cyc(1, 12'h004, 32'h0020A423, 0, 0);
        chk("sw_imm", out_imm, 32'h8);
        chk("sw_memw", 32'(out_mem_write), 32'd1);
        cyc(1, 12'h008, 32'hFE000EE3, 1, 0);
        chk("beq_imm", out_imm, 32'hFFFFFFFC);
        chk("beq_branch", 32'(out_branch), 32'd1);
        cyc(1, 12'h00C, 32'h123452B7, 1, 0);
        chk("lui_imm", out_imm, 32'h12345000);
        chk("lui_rd", 32'(out_rd), 32'd5);
        chk("lui_rw", 32'(out_reg_write), 32'd1);
        cyc(1, 12'h010, 32'h00000000, 1, 0);
        chk("ill_flags", 32'(w_fl), 32'b0000001);
        cyc(0, 0, 0, 1, 0);
        chk("drain", 32'(out_count), 32'd0);
        cyc(1, 12'h000, 32'h00000013, 0, 0);
        cyc(1, 12'h004, 32'h00000013, 0, 0);
        cyc(1, 12'h008, 32'h00000013, 0, 0);
        chk("bp_ready", 32'(in_ready), 32'd0);
        chk("bp_count", 32'(out_count), 32'd2);
        chk("bp_pc0", 32'(out_pc), 32'h0);
        cyc(1, 12'h008, 32'h00000013, 1, 0);
        chk("full_pop_count", 32'(out_count), 32'd1);
        chk("bp_pc4", 32'(out_pc), 32'h4);
        cyc(1, 12'h008, 32'h00000013, 0, 0);
        chk("refill_count", 32'(out_count), 32'd2);
        cyc(0, 0, 0, 1, 0);
        chk("bp_pc8", 32'(out_pc), 32'h8);
        cyc(0, 0, 0, 1, 0);
        cyc(1, 12'h020, 32'h00000013, 0, 0);
        cyc(1, 12'h024, 32'h00000013, 0, 0);
        cyc(1, 12'h028, 32'h00000013, 0, 1);
        chk("flush_count", 32'(out_count), 32'd0);
        chk("flush_valid", 32'(out_valid), 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("flush_drop", 32'(out_count), 32'd0);
        for (int i = 0; i < 600; i++) begin
            automatic logic [31:0] r = $urandom();
            automatic logic [6:0] op = ops[$urandom_range(0, 9)];
            automatic logic [AW-1:0] pc = AW'($urandom());
            if (i == 300) begin
                #2;
                rst_n = 0;
                #1;
                chk("arst_valid", 32'(out_valid), 32'd0);
                chk("arst_ready", 32'(in_ready), 32'd1);
                chk("arst_count", 32'(out_count), 32'd0);
                @(negedge clk);
                rst_n = 1;
                @(posedge clk);
                #1;
            end
            cyc($urandom_range(0, 3) != 0, pc, {r[31:7], op}, $urandom_range(0, 2) != 0,
                $urandom_range(0, 40) == 0);
        end
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
